// File: rtl/audio_pkg.sv
// Shared audio datapath types and sizing for the feeder, convolver and IR line store.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package audio_pkg;

    localparam int SAMPLE_WIDTH = 16;
    localparam int LINE_SAMPLES = 64;
    localparam int NUM_SEGMENTS = 4;

    localparam int LINE_WIDTH = SAMPLE_WIDTH * LINE_SAMPLES;
    localparam int HIST_DEPTH = LINE_SAMPLES * NUM_SEGMENTS;
    localparam int HIST_BITS  = HIST_DEPTH * SAMPLE_WIDTH;
    localparam int SEG_W      = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
    typedef logic [LINE_WIDTH-1:0]          audio_line_t;
    typedef logic [SEG_W-1:0]               seg_idx_t;

    // Feeder sequencing: waiting for a sample, or streaming its segment lines.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } feed_state_t;

endpackage

// File: rtl/sample_history_shift.sv
// Sliding window of the most recent HIST_DEPTH samples; entry 0 (bits [15:0]) is the newest.
// Latency: a shifted-in sample appears on history the cycle after shift_en.
// Backpressure: none; holds its contents whenever shift_en is low.
module sample_history_shift
    import audio_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_en,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic [HIST_BITS-1:0] history
);

    // Push the new sample into slot 0; the oldest falls off the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            history <= '0;
        end else if (shift_en) begin
            history <= {history[HIST_BITS-SAMPLE_WIDTH-1:0], sample};
        end
    end

endmodule

// File: rtl/audio_line_feeder.sv
// Turns each accepted audio sample into NUM_SEGMENTS slot-reversed 1024-bit lines for the convolver.
// Latency: first line is valid the cycle after the sample is accepted; one line per cycle when unstalled.
// Backpressure: line_ready_in low freezes the current line; new samples are refused (and flagged) until the burst ends.
module audio_line_feeder
    import audio_pkg::*;
(
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid_in,
    output logic                    sample_ready_out,
    output logic                    overrun_out,
    output logic [LINE_WIDTH-1:0]   audio_line_out,
    output logic [SEG_W-1:0]        segment_out,
    output logic                    line_valid_out,
    output logic                    line_last_out,
    input  logic                    line_ready_in
);

    localparam seg_idx_t LAST_SEG = seg_idx_t'(NUM_SEGMENTS - 1);

    feed_state_t         state_q;
    feed_state_t         state_d;
    seg_idx_t            seg_q;
    seg_idx_t            seg_d;
    logic                overrun_q;
    logic                accept;
    logic [HIST_BITS-1:0] hist_flat;
    audio_line_t         seg_window;
    audio_line_t         packed_line;

    assign accept      = sample_valid_in && sample_ready_out;
    assign overrun_out = overrun_q;

    sample_history_shift u_hist (
        .clk      (clk_in),
        .rst      (rst_in),
        .shift_en (accept),
        .sample   (sample_in),
        .history  (hist_flat)
    );

    // State and segment counter registers; reset abandons any burst in flight.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            seg_q   <= '0;
        end else begin
            state_q <= state_d;
            seg_q   <= seg_d;
        end
    end

    // Next-state logic plus the handshake outputs derived from the state.
    always_comb begin
        state_d          = state_q;
        seg_d            = seg_q;
        sample_ready_out = 1'b0;
        line_valid_out   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sample_ready_out = !rst_in;
                if (sample_valid_in && !rst_in) begin
                    state_d = ST_EMIT;
                    seg_d   = '0;
                end
            end
            ST_EMIT: begin
                line_valid_out = 1'b1;
                if (line_ready_in) begin
                    if (seg_q == LAST_SEG) begin
                        state_d = ST_IDLE;
                        seg_d   = '0;
                    end else begin
                        seg_d = seg_q + seg_idx_t'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                seg_d   = '0;
            end
        endcase
    end

    // A sample offered while busy is dropped; report it for exactly one cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= sample_valid_in && !sample_ready_out;
        end
    end

    // Select the segment's 64 samples and reverse them so the newest lands in slot 63,
    // which lines it up with IR slot 0 in the convolver's i <-> 63-i pairing.
    always_comb begin
        seg_window  = hist_flat[int'(seg_q)*LINE_WIDTH +: LINE_WIDTH];
        packed_line = '0;
        for (int j = 0; j < LINE_SAMPLES; j++) begin
            packed_line[j*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                seg_window[(LINE_SAMPLES-1-j)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
    end

    // Line outputs are forced to zero whenever no line is being offered.
    always_comb begin
        audio_line_out = '0;
        segment_out    = '0;
        line_last_out  = 1'b0;
        if (state_q == ST_EMIT) begin
            audio_line_out = packed_line;
            segment_out    = seg_q;
            line_last_out  = (seg_q == LAST_SEG);
        end
    end

endmodule

// File: tb/tb_audio_line_feeder.sv
module tb_audio_line_feeder;
    import audio_pkg::*;

    localparam int SW = SAMPLE_WIDTH;
    localparam int LW = LINE_WIDTH;
    localparam int NS = NUM_SEGMENTS;
    localparam int HD = HIST_DEPTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] sample = '0;
    logic          svalid = 1'b0;
    logic          sready;
    logic          overrun;
    logic [LW-1:0] line;
    logic [SEG_W-1:0] seg;
    logic          lvalid;
    logic          llast;
    logic          lready = 1'b1;

    int n_chk  = 0;
    int n_fail = 0;
    int rdy_mode = 1; // 0 random, 1 held high, 2 held low

    typedef struct {
        logic [LW-1:0] line;
        int            seg;
    } exp_t;

    exp_t          exp_q[$];
    logic [SW-1:0] mhist [HD];
    logic [LW-1:0] got_line [NS];

    audio_line_feeder dut (
        .clk_in           (clk),
        .rst_in           (rst),
        .sample_in        (sample),
        .sample_valid_in  (svalid),
        .sample_ready_out (sready),
        .overrun_out      (overrun),
        .audio_line_out   (line),
        .segment_out      (seg),
        .line_valid_out   (lvalid),
        .line_last_out    (llast),
        .line_ready_in    (lready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        int first;
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            first = 0;
            for (int j = LINE_SAMPLES - 1; j >= 0; j--)
                if (act[j*SW +: SW] !== exp[j*SW +: SW]) first = j;
            $display("FAIL %s: slot %0d got %h required %h", name, first,
                     act[first*SW +: SW], exp[first*SW +: SW]);
        end
    endtask

    // Reference: history as a plain array, newest at index 0; line slot j = hist[k*64 + 63 - j].
    task automatic model_accept(input logic [SW-1:0] s);
        exp_t e;
        for (int i = HD - 1; i > 0; i--) mhist[i] = mhist[i-1];
        mhist[0] = s;
        for (int k = 0; k < NS; k++) begin
            e.seg  = k;
            e.line = '0;
            for (int j = 0; j < LINE_SAMPLES; j++)
                e.line[j*SW +: SW] = mhist[k*LINE_SAMPLES + (LINE_SAMPLES - 1 - j)];
            exp_q.push_back(e);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < HD; i++) mhist[i] = '0;
        exp_q.delete();
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic send_sample(input logic [SW-1:0] s);
        int w;
        w = 0;
        step();
        while (sready !== 1'b1 && w < 100) begin
            step();
            w++;
        end
        if (w >= 100) begin
            chk("send_ready_timeout", 32'(sready), 32'd1);
            return;
        end
        sample = s;
        svalid = 1'b1;
        model_accept(s);
        @(posedge clk);
        #1;
        svalid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_seg(input int k);
        int w;
        w = 0;
        step();
        while (!(lvalid === 1'b1 && int'(seg) == k) && w < 50) begin
            step();
            w++;
        end
        if (w >= 50) chk("wait_segment_timeout", 32'(seg), 32'(k));
    endtask

    task automatic do_reset(input int cycles);
        step();
        rst = 1'b1;
        model_clear();
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Downstream ready generator: changes just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       lready = ($urandom_range(0, 3) != 0);
                1:       lready = 1'b1;
                default: lready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks idle/hold behaviour.
    logic          prev_stall = 1'b0;
    logic [LW-1:0] prev_line;
    logic [SEG_W-1:0] prev_seg;
    exp_t          mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(lvalid), 32'd1);
                chk("hold_segment", 32'(seg), 32'(prev_seg));
                chk_line("hold_line", line, prev_line);
            end
            if (lvalid === 1'b1) begin
                chk("last_flag", 32'(llast), 32'(int'(seg) == NS - 1));
                chk("ready_low_in_emit", 32'(sready), 32'd0);
                if (lready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_line_queue", 32'd0, 32'd1);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("segment_index", 32'(seg), 32'(mon_e.seg));
                        chk_line("line_data", line, mon_e.line);
                        got_line[mon_e.seg] = line;
                    end
                end
            end else begin
                chk_line("idle_line_zero", line, '0);
                chk("idle_segment_zero", 32'(seg), 32'd0);
                chk("idle_last_zero", 32'(llast), 32'd0);
                chk("idle_ready_high", 32'(sready), 32'd1);
            end
            prev_stall = lvalid && !lready;
            prev_line  = line;
            prev_seg   = seg;
        end
    end

    initial begin : stim
        logic [LW-1:0] e;
        logic [LW-1:0] t;
        int beef;

        model_clear();
        for (int k = 0; k < NS; k++) got_line[k] = '0;

        // Reset with a sample offered throughout: it must be ignored and not flag overrun.
        rst = 1'b1;
        svalid = 1'b1;
        sample = 16'hBEEF;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        svalid = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(sready), 32'd1);
        chk("reset_valid", 32'(lvalid), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_last", 32'(llast), 32'd0);
        chk_line("reset_line", line, '0);

        // Single sample, ready held high: four consecutive lines, last on k=3.
        rdy_mode = 1;
        send_sample(16'h1234);
        repeat (4) @(negedge clk);
        chk("single_k3_valid", 32'(lvalid), 32'd1);
        chk("single_k3_last", 32'(llast), 32'd1);
        chk("single_k3_seg", 32'(seg), 32'd3);
        @(negedge clk);
        chk("single_ready_back", 32'(sready), 32'd1);
        chk("single_valid_done", 32'(lvalid), 32'd0);
        e = '0;
        e[LW-1 -: SW] = 16'h1234;
        chk_line("single_seg0", got_line[0], e);
        for (int k = 1; k < NS; k++) chk_line("single_seg_zero", got_line[k], '0);

        // Ramp 1..70 from clean history.
        do_reset(2);
        for (int i = 1; i <= 70; i++) send_sample(16'(i));
        wait_drain();
        t = got_line[0];
        chk("ramp_s0_slot63", 32'(t[63*SW +: SW]), 32'd70);
        chk("ramp_s0_slot0", 32'(t[0 +: SW]), 32'd7);
        t = got_line[1];
        chk("ramp_s1_slot63", 32'(t[63*SW +: SW]), 32'd6);
        chk("ramp_s1_slot58", 32'(t[58*SW +: SW]), 32'd1);
        chk("ramp_s1_slot57", 32'(t[57*SW +: SW]), 32'd0);

        // Backpressure at k=2.
        send_sample(16'h0500);
        wait_seg(1);
        rdy_mode = 2;
        step();
        chk("bp_seg_start", 32'(seg), 32'd2);
        repeat (4) begin
            step();
            chk("bp_valid_held", 32'(lvalid), 32'd1);
            chk("bp_seg_held", 32'(seg), 32'd2);
        end
        rdy_mode = 1;
        wait_drain();

        // Overrun during a burst.
        send_sample(16'h0600);
        step();
        chk("ovr_busy", 32'(sready), 32'd0);
        sample = 16'hBEEF;
        svalid = 1'b1;
        @(posedge clk);
        #1;
        svalid = 1'b0;
        @(negedge clk);
        chk("ovr_pulse", 32'(overrun), 32'd1);
        @(negedge clk);
        chk("ovr_pulse_end", 32'(overrun), 32'd0);
        wait_drain();
        send_sample(16'h0601);
        wait_drain();
        beef = 0;
        for (int k = 0; k < NS; k++) begin
            t = got_line[k];
            for (int j = 0; j < LINE_SAMPLES; j++)
                if (t[j*SW +: SW] == 16'hBEEF) beef++;
        end
        chk("ovr_sample_dropped", 32'(beef), 32'd0);

        // Reset in the middle of a burst.
        send_sample(16'h0700);
        wait_seg(1);
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(lvalid), 32'd0);
        chk_line("midrst_line", line, '0);
        send_sample(16'h0001);
        wait_drain();
        e = '0;
        e[LW-1 -: SW] = 16'h0001;
        chk_line("midrst_seg0", got_line[0], e);
        for (int k = 1; k < NS; k++) chk_line("midrst_seg_zero", got_line[k], '0);

        // Randomized samples and randomized downstream readiness.
        rdy_mode = 0;
        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 3)) step();
            send_sample(16'($urandom));
        end
        wait_drain();
        rdy_mode = 1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
